// File: rtl/aes_decrypt_top_if.sv
// Start/data request and result bundle for the iterative AES-128 decryptor.
interface aes_decrypt_top_if;
  logic         i_start;
  logic [127:0] i_ciphertext;
  logic [127:0] i_key;
  logic [127:0] o_plaintext;
  logic         o_valid;
  logic         o_busy;

  modport master (output i_start, i_ciphertext, i_key,
                  input  o_plaintext, o_valid, o_busy);
  modport slave  (input  i_start, i_ciphertext, i_key,
                  output o_plaintext, o_valid, o_busy);
endinterface

// File: rtl/aes_decrypt_top.sv
// Iterative AES-128 inverse cipher: one transform stage per clock, round keys
// expanded combinationally from the latched key and applied 10 down to 0.
package aes_dec_pkg;
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] p, t;
    p = '0;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (z[i]) p = p ^ t;
      t = xt(t);
    end
    return p;
  endfunction

  // x^254 == x^-1 in GF(2^8); zero maps to zero as the S-box requires
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] sq, r;
    sq = x;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] rcon(input int r);
    logic [7:0] c;
    c = 8'h01;
    for (int i = 1; i < r; i++) c = xt(c);
    return c;
  endfunction
endpackage

// One byte lane of the S-box; MODE=1 selects the inverse table.
module aes_sbox_lane #(
  parameter bit MODE = 1'b0
) (
  input  logic [7:0] a,
  output logic [7:0] y
);
  import aes_dec_pkg::*;

  if (MODE) begin : g_inv
    assign y = ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
  end else begin : g_fwd
    logic [7:0] inv;
    assign inv = ginv(a);
    assign y   = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  end
endmodule

module aes_decrypt_top #(
  parameter int NR = 10
) (
  input logic              clk,
  input logic              rst_n,
  aes_decrypt_top_if.slave bus
);
  import aes_dec_pkg::*;

  localparam int NUM_LANES = 16;

  typedef enum logic [3:0] {
    IDLE, INIT, ISHIFT_R, ISUB_R, ADD_R, IMIX_R, ISHIFT_F, ISUB_F, ADD_F, DONE
  } state_t;

  state_t       state, state_nx;
  logic         accept;
  logic [127:0] ct_q, key_q, st, pt_q, sub_st, rk_cur;
  logic [3:0]   rc;
  logic [127:0] rk [NR+1];

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  // Key expansion: each round block owns its key so the chain stays acyclic per signal
  assign rk[0] = key_q;
  for (genvar r = 1; r <= NR; r++) begin : g_ks
    logic [127:0] prev, k;
    logic [31:0]  rot, sw, w0, w1, w2, w3;
    if (r == 1) begin : g_first
      assign prev = key_q;
    end else begin : g_next
      assign prev = g_ks[r-1].k;
    end
    assign rot = {prev[23:0], prev[31:24]};
    for (genvar b = 0; b < 4; b++) begin : g_sb
      aes_sbox_lane #(.MODE(1'b0)) u_sb (.a(rot[8*b +: 8]), .y(sw[8*b +: 8]));
    end
    assign w0 = prev[127:96] ^ sw ^ {rcon(r), 24'h0};
    assign w1 = prev[95:64]  ^ w0;
    assign w2 = prev[63:32]  ^ w1;
    assign w3 = prev[31:0]   ^ w2;
    assign k  = {w0, w1, w2, w3};
    assign rk[r] = k;
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_isb
    aes_sbox_lane #(.MODE(1'b1)) u_isb (.a(st[8*i +: 8]), .y(sub_st[8*i +: 8]));
  end

  always_comb begin
    rk_cur = '0;
    for (int i = 0; i <= NR; i++)
      if (rc == 4'(i)) rk_cur = rk[i];
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      IDLE, DONE: if (bus.i_start) begin
        state_nx = INIT;
        accept   = 1'b1;
      end
      INIT:     state_nx = ISHIFT_R;
      ISHIFT_R: state_nx = ISUB_R;
      ISUB_R:   state_nx = ADD_R;
      ADD_R:    state_nx = IMIX_R;
      IMIX_R:   state_nx = (rc != 4'd1) ? ISHIFT_R : ISHIFT_F;
      ISHIFT_F: state_nx = ISUB_F;
      ISUB_F:   state_nx = ADD_F;
      ADD_F:    state_nx = DONE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ct_q  <= '0;
      key_q <= '0;
      st    <= '0;
      pt_q  <= '0;
      rc    <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        ct_q  <= bus.i_ciphertext;
        key_q <= bus.i_key;
      end
      case (state)
        INIT: begin
          st <= ct_q ^ rk[NR];
          rc <= 4'(NR - 1);
        end
        ISHIFT_R, ISHIFT_F: st <= inv_shift_rows(st);
        ISUB_R, ISUB_F:     st <= sub_st;
        ADD_R:              st <= st ^ rk_cur;
        IMIX_R: begin
          st <= inv_mix_columns(st);
          rc <= rc - 4'd1;
        end
        ADD_F: begin
          st   <= st ^ rk[0];
          pt_q <= st ^ rk[0];
        end
        default: ;
      endcase
    end
  end

  assign bus.o_plaintext = pt_q;
  assign bus.o_valid     = (state == DONE);
  assign bus.o_busy      = (state != IDLE) && (state != DONE);
endmodule
